// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM bidirectional PIO.
package pio_pkg;

  // Word addresses of the register map
  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_DIR      = 3'd1;
  localparam logic [2:0] ADDR_MASK     = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  // Edge selection
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Interrupt source selection
  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Multi-stage input synchroniser followed by a per-bit edge detector.
module pio_sync_edge
  import pio_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] edge_pulse
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  delay_q;
  logic [WIDTH-1:0]                  rise;
  logic [WIDTH-1:0]                  fall;

  // Shift pins through the synchroniser, then one extra delay for edge compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      delay_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Select which edge polarity produces a capture pulse
  always_comb begin
    rise = sync_in & ~delay_q;
    fall = ~sync_in & delay_q;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_pulse = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_pulse = fall;
    end else begin
      edge_pulse = rise | fall;
    end
  end

endmodule

// File: rtl/avalon_pio_bidir.sv
// Avalon-MM slave GPIO: per-bit direction, edge capture, masked irq, atomic set/clear.
module avalon_pio_bidir
  import pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_OUT   = 32'h0,
  parameter logic [31:0] RESET_DIR   = 32'h0,
  parameter int unsigned EDGE_TYPE   = EDGE_RISE,
  parameter int unsigned IRQ_MODE    = IRQ_EDGE,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [DATA_WIDTH-1:0] dir_q, dir_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [DATA_WIDTH-1:0] sync_in;
  logic [DATA_WIDTH-1:0] edge_pulse;
  logic [DATA_WIDTH-1:0] wd;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  wr;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[DATA_WIDTH-1:0];

  if (DATA_WIDTH < 32) begin : g_unused_wd
    logic unused_wd;
    assign unused_wd = ^writedata[31:DATA_WIDTH];
  end

  pio_sync_edge #(
    .WIDTH      (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE_TYPE  (EDGE_TYPE)
  ) u_sync_edge (
    .clk       (clk),
    .reset_n   (reset_n),
    .async_in  (in_port),
    .sync_in   (sync_in),
    .edge_pulse(edge_pulse)
  );

  // Register writes; a new edge always wins over a same-cycle W1C
  always_comb begin
    data_out_d = data_out_q;
    dir_d      = dir_q;
    mask_d     = mask_q;
    edge_cap_d = edge_cap_q;
    if (wr) begin
      case (address)
        ADDR_DATA:     data_out_d = wd;
        ADDR_DIR:      dir_d      = wd;
        ADDR_MASK:     mask_d     = wd;
        ADDR_EDGE_CAP: edge_cap_d = edge_cap_q & ~wd;
        ADDR_OUTSET:   data_out_d = data_out_q | wd;
        ADDR_OUTCLEAR: data_out_d = data_out_q & ~wd;
        default:       ;
      endcase
    end
    edge_cap_d = edge_cap_d | edge_pulse;
  end

  // Register state with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out_q <= RESET_OUT[DATA_WIDTH-1:0];
      dir_q      <= RESET_DIR[DATA_WIDTH-1:0];
      mask_q     <= '0;
      edge_cap_q <= '0;
    end else begin
      data_out_q <= data_out_d;
      dir_q      <= dir_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
    end
  end

  // Zero-wait-state read mux; outputs read back the driven value, inputs the pin
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:     rd_val = (dir_q & data_out_q) | (~dir_q & sync_in);
      ADDR_DIR:      rd_val = dir_q;
      ADDR_MASK:     rd_val = mask_q;
      ADDR_EDGE_CAP: rd_val = edge_cap_q;
      default:       rd_val = '0;
    endcase
  end

  assign readdata = 32'(rd_val);
  assign out_port = data_out_q;
  assign out_en   = dir_q;

  if (IRQ_MODE == IRQ_EDGE) begin : g_irq_edge
    assign irq = |(edge_cap_q & mask_q);
  end else begin : g_irq_level
    assign irq = |(sync_in & ~dir_q & mask_q);
  end

endmodule

// File: tb/tb_avalon_pio_bidir.sv
// Self-checking bench: two PIO configurations on a shared bus against a behavioural model.
module tb_avalon_pio_bidir;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rd_a, rd_b;
  logic [7:0]  op_a, op_b, oe_a, oe_b;
  logic        irq_a, irq_b;

  int vectors;
  int miscompares;

  // A: rising edge, edge irq, 2 stages, non-zero reset values
  avalon_pio_bidir #(
    .DATA_WIDTH (8),
    .RESET_OUT  (32'hA5),
    .RESET_DIR  (32'hFF),
    .EDGE_TYPE  (0),
    .IRQ_MODE   (1),
    .SYNC_STAGES(2)
  ) u_dut_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (rd_a),
    .in_port   (in_port),
    .out_port  (op_a),
    .out_en    (oe_a),
    .irq       (irq_a)
  );

  // B: any edge, level irq, 3 stages, zero reset values
  avalon_pio_bidir #(
    .DATA_WIDTH (8),
    .RESET_OUT  (32'h0),
    .RESET_DIR  (32'h0),
    .EDGE_TYPE  (2),
    .IRQ_MODE   (0),
    .SYNC_STAGES(3)
  ) u_dut_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (rd_b),
    .in_port   (in_port),
    .out_port  (op_b),
    .out_en    (oe_b),
    .irq       (irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: architectural registers plus the history of sampled pins
  logic [7:0] m_out  [2];
  logic [7:0] m_dir  [2];
  logic [7:0] m_mask [2];
  logic [7:0] m_cap  [2];
  logic [7:0] m_hist [2][5];

  function automatic int stages(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic logic [7:0] m_sync(int d);
    return m_hist[d][stages(d)-1];
  endfunction

  function automatic logic [31:0] exp_read(int d, logic [2:0] a);
    logic [7:0] v;
    case (a)
      3'd0:    v = (m_dir[d] & m_out[d]) | (~m_dir[d] & m_sync(d));
      3'd1:    v = m_dir[d];
      3'd2:    v = m_mask[d];
      3'd3:    v = m_cap[d];
      default: v = 8'h00;
    endcase
    return {24'h0, v};
  endfunction

  function automatic logic exp_irq(int d);
    if (d == 0) return |(m_cap[d] & m_mask[d]);
    return |(m_sync(d) & ~m_dir[d] & m_mask[d]);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_out[d]  = (d == 0) ? 8'hA5 : 8'h00;
      m_dir[d]  = (d == 0) ? 8'hFF : 8'h00;
      m_mask[d] = 8'h00;
      m_cap[d]  = 8'h00;
      for (int j = 0; j < 5; j++) m_hist[d][j] = 8'h00;
    end
  endtask

  // Effect of one clock edge given the inputs currently presented
  task automatic model_clock();
    logic [7:0] si, sd, ev, wd, cap;
    if (!reset_n) begin
      model_reset();
      return;
    end
    wd = writedata[7:0];
    for (int d = 0; d < 2; d++) begin
      si  = m_hist[d][stages(d)-1];
      sd  = m_hist[d][stages(d)];
      ev  = (d == 0) ? (si & ~sd) : (si ^ sd);
      cap = m_cap[d];
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_out[d]  = wd;
          3'd1: m_dir[d]  = wd;
          3'd2: m_mask[d] = wd;
          3'd3: cap       = cap & ~wd;
          3'd4: m_out[d]  = m_out[d] | wd;
          3'd5: m_out[d]  = m_out[d] & ~wd;
          default: ;
        endcase
      end
      m_cap[d] = cap | ev;
      for (int j = 4; j > 0; j--) m_hist[d][j] = m_hist[d][j-1];
      m_hist[d][0] = in_port;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("rd_a",   rd_a, exp_read(0, address));
    chk("rd_b",   rd_b, exp_read(1, address));
    chk("out_a",  {24'h0, op_a}, {24'h0, m_out[0]});
    chk("out_b",  {24'h0, op_b}, {24'h0, m_out[1]});
    chk("oe_a",   {24'h0, oe_a}, {24'h0, m_dir[0]});
    chk("oe_b",   {24'h0, oe_b}, {24'h0, m_dir[1]});
    chk("irq_a",  {31'h0, irq_a}, {31'h0, exp_irq(0)});
    chk("irq_b",  {31'h0, irq_b}, {31'h0, exp_irq(1)});
  endtask

  task automatic cyc();
    model_clock();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic bus_wr(logic [2:0] a, logic [7:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = {$urandom_range(0, 32'hFFFFFF), d};
    cyc();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic set_addr(logic [2:0] a);
    address = a;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b1;
    address     = 3'd0;
    chipselect  = 1'b0;
    write_n     = 1'b1;
    writedata   = 32'h0;
    in_port     = 8'h00;

    // Reset values visible asynchronously
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_out_a", {24'h0, op_a}, 32'hA5);
    chk("rst_oe_a",  {24'h0, oe_a}, 32'hFF);
    chk("rst_rd0_a", rd_a, 32'h0000_00A5);
    chk("rst_irq_a", {31'h0, irq_a}, 32'h0);
    check_all();
    cyc();
    cyc();
    @(negedge clk);
    reset_n = 1'b1;
    cyc();

    // Mixed direction read-back
    bus_wr(3'd1, 8'h0F);
    bus_wr(3'd0, 8'h3C);
    in_port = 8'hF0;
    cyc();
    cyc();
    set_addr(3'd0);
    chk("mixed_rd0_a", rd_a, 32'h0000_00FC);
    check_all();

    // Atomic set/clear
    bus_wr(3'd0, 8'h00);
    bus_wr(3'd4, 8'h81);
    chk("outset_a", {24'h0, op_a}, 32'h81);
    bus_wr(3'd5, 8'h01);
    chk("outclr_a", {24'h0, op_a}, 32'h80);
    set_addr(3'd4);
    chk("rd4_a", rd_a, 32'h0);
    set_addr(3'd5);
    chk("rd5_a", rd_a, 32'h0);

    // Edge capture latency, W1C, and set-wins-over-clear
    bus_wr(3'd3, 8'hFF);
    bus_wr(3'd2, 8'h01);
    set_addr(3'd3);
    in_port = 8'hF1;
    cyc();
    cyc();
    chk("cap_early_a", rd_a, 32'h0);
    cyc();
    chk("cap_set_a", rd_a, 32'h01);
    chk("cap_irq_a", {31'h0, irq_a}, 32'h1);
    bus_wr(3'd3, 8'h01);
    chk("w1c_a", rd_a, 32'h0);
    chk("w1c_irq_a", {31'h0, irq_a}, 32'h0);
    in_port = 8'hF0;
    repeat (4) cyc();
    in_port = 8'hF1;
    cyc();
    cyc();
    bus_wr(3'd3, 8'h01);
    set_addr(3'd3);
    chk("setwins_a", rd_a, 32'h01);

    // Level irq on B follows the synchronised pin, drops right after unmasking
    bus_wr(3'd1, 8'h00);
    bus_wr(3'd2, 8'h02);
    in_port = 8'h02;
    repeat (4) cyc();
    chk("lvl_irq_b", {31'h0, irq_b}, 32'h1);
    bus_wr(3'd2, 8'h00);
    chk("lvl_drop_b", {31'h0, irq_b}, 32'h0);
    in_port = 8'h00;
    repeat (4) cyc();

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      address    = 3'($urandom_range(0, 7));
      chipselect = 1'($urandom);
      write_n    = 1'($urandom);
      writedata  = $urandom;
      if ($urandom_range(0, 3) == 0) in_port = 8'($urandom);
      cyc();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;

    // Asynchronous reset mid-sequence
    in_port = 8'h00;
    repeat (5) cyc();
    in_port = 8'hFF;
    repeat (5) cyc();
    bus_wr(3'd2, 8'hFF);
    bus_wr(3'd0, 8'h55);
    set_addr(3'd3);
    chk("pre_rst_cap_a", rd_a, 32'hFF);
    chk("pre_rst_out_a", {24'h0, op_a}, 32'h55);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("arst_cap_a", rd_a, 32'h0);
    chk("arst_out_a", {24'h0, op_a}, 32'hA5);
    chk("arst_irq_a", {31'h0, irq_a}, 32'h0);
    check_all();
    cyc();
    @(negedge clk);
    reset_n = 1'b1;
    in_port = 8'h00;
    cyc();

    // Unused addresses: writes ignored, reads zero
    bus_wr(3'd6, 8'hFF);
    bus_wr(3'd7, 8'hFF);
    set_addr(3'd6);
    chk("rd6_a", rd_a, 32'h0);
    set_addr(3'd7);
    chk("rd7_b", rd_b, 32'h0);
    set_addr(3'd2);
    chk("mask_kept_a", rd_a, 32'h0);
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/avalon_pio_bidir.md
Name: avalon_pio_bidir

Overview:
- Parametrised Avalon-MM slave general-purpose I/O port; next generation of the team's fixed 2-bit output-only PIO.
- Adds per-bit direction, synchronised inputs, edge capture, an interrupt mask with a single irq line, and atomic set/clear of output bits.
- Sits on the HPS/NIOS lightweight bridge. Typical uses: alive-test LEDs, mailbox doorbells, board status pins.

Parameters:
- DATA_WIDTH, 8: port width, 1..32.
- RESET_OUT, 0: reset value of the output data register (low DATA_WIDTH bits used).
- RESET_DIR, 0: reset value of the direction register; bit = 1 means output.
- EDGE_TYPE, 0: edge detected per bit; 0 = rising, 1 = falling, 2 = any.
- IRQ_MODE, 1: 0 = level (from synchronised input), 1 = edge (from capture register).
- SYNC_STAGES, 2: input synchroniser depth, 2..4.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- address  in  3  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, zero wait states, combinational from registers
- in_port  in  DATA_WIDTH  external pins (asynchronous)
- out_port  out  DATA_WIDTH  output data register
- out_en  out  DATA_WIDTH  direction register, drives pad output enables
- irq  out  1  interrupt request, active high

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (reset_n); all flops clear on its assertion regardless of clk.
- Reset values:
  - data_out = RESET_OUT, dir = RESET_DIR.
  - mask = 0, edge_cap = 0.
  - Synchroniser and edge-delay flops = 0.
  - Result: irq = 0 during and after reset.
- Write strobe: wr = chipselect & ~write_n. It takes effect on the next clk edge; only writedata[DATA_WIDTH-1:0] is used.
- Register map (word addresses):
  - 0 DATA. Write: data_out <= wd. Read bit i: dir[i] ? data_out[i] : sync_in[i].
  - 1 DIRECTION. Read/write.
  - 2 IRQ_MASK. Read/write.
  - 3 EDGE_CAP. Read returns edge_cap. Write-1-to-clear per bit.
  - 4 OUTSET. Write: data_out <= data_out | wd. Reads 0.
  - 5 OUTCLEAR. Write: data_out <= data_out & ~wd. Reads 0.
  - 6, 7: writes ignored, reads 0.
- Read rules:
  - readdata bits [31:DATA_WIDTH] are always 0.
  - readdata is valid in the same cycle as address.
  - No read strobe; reads have no side effects.
- Synchroniser: in_port passes through SYNC_STAGES flops to give sync_in, then one more flop to give sync_d.
- Edge detection per bit:
  - rise = sync_in & ~sync_d; fall = ~sync_in & sync_d.
  - The selected edge sets edge_cap[i] on the next clk edge.
  - Edge detection is not gated by dir or mask; capture is always recorded.
- Latency:
  - An in_port change meeting setup before edge k is visible in DATA reads after edge k+SYNC_STAGES-1.
  - The corresponding edge_cap bit is set at edge k+SYNC_STAGES.
  - In edge mode, irq asserts in the same cycle as that edge_cap bit.
- Simultaneous edge detect and W1C on the same bit in the same cycle: set wins, edge_cap stays 1 (no lost event).
- irq:
  - Edge mode: irq = |(edge_cap & mask).
  - Level mode: irq = |(sync_in & ~dir & mask).
  - Combinational from registers, so no extra latency after a mask write.
- out_port = data_out and out_en = dir, both unconditionally (no masking by dir).
- Pulses narrower than one clk period may be missed; this is documented, not an error.

Decomposition:
- Shared package pio_pkg holds:
  - Address constants ADDR_DATA..ADDR_OUTCLEAR.
  - EDGE_RISE / EDGE_FALL / EDGE_ANY.
  - IRQ_LEVEL / IRQ_EDGE.
- One sub-module, pio_sync_edge: per-vector synchroniser plus edge detector. Parameters WIDTH, SYNC_STAGES, EDGE_TYPE; outputs sync_in and edge_pulse.
- Register file, read mux and irq logic stay in the top module.

Test Plan:
- Reset with RESET_OUT=8'hA5, RESET_DIR=8'hFF: out_port=A5 and out_en=FF during reset; read addr0=0x000000A5, irq=0.
- Write DIR=0x0F, DATA=0x3C; drive in_port=0xF0, wait SYNC_STAGES cycles, read addr0: returns 0x000000FC.
- OUTSET 0x81 then OUTCLEAR 0x01 starting from data_out=0x00: out_port goes 0x81, then 0x80. Reads of addr4 and addr5 return 0.
- EDGE_TYPE=0, IRQ_MODE=1, mask=0x01, in_port[0] 0->1:
  - edge_cap=0x01 and irq=1 exactly SYNC_STAGES+1 edges after the pin change.
  - W1C 0x01 clears both. A W1C coinciding with a new edge leaves edge_cap=0x01.
- IRQ_MODE=0, dir=0, mask=0x02: hold in_port[1]=1, irq follows sync_in[1]; writing mask=0 drops irq in the next cycle.
- Assert reset_n mid-sequence (edge_cap=0xFF, data_out=0x55): all registers clear immediately, asynchronously; address 6/7 writes have no effect and read 0.
